// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM command-port arbiter, the SDRAM controller
// and the video fetcher: default bus widths, FSM state and owner encodings.
package sdram_port_arbiter_pkg;

  // Default widths shared with the SDRAM controller and the video fetcher
  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 16;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  // Burst owner encoding
  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_WR  = 1'b1
  } owner_e;

  // Beat counter must be able to hold BURST_LEN itself, hence the extra bit
  function automatic int beat_cnt_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/sdram_prio_starve.sv
// Priority decision between the video fetcher and the framebuffer writer.
// Video wins by default; after STARVE_MAX consecutive video grants made while
// the writer was waiting, the writer is forced through once.
module sdram_prio_starve
  import sdram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic mem_clk,
  input  logic reset,
  input  logic vid_req,
  input  logic wr_req,
  input  logic grant_en,   // arbiter is free to grant this cycle
  output logic win_valid,  // some requester wins this cycle
  output logic win_owner   // OWN_VID / OWN_WR
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             wr_wins;

  // Winner selection: writer only when video is idle or writer is starved
  always_comb begin
    wr_wins   = wr_req && (!vid_req || (starve_cnt_reg == STARVE_LIM));
    win_valid = vid_req || wr_req;
    win_owner = wr_wins ? 1'(OWN_WR) : 1'(OWN_VID);
  end

  // Starve counter update: count video grants taken while writer waits
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!wr_req) begin
      starve_cnt_next = '0;
    end else if (grant_en && win_valid) begin
      if (wr_wins) begin
        starve_cnt_next = '0;
      end else if (starve_cnt_reg != STARVE_LIM) begin
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Starve counter register
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port between the video line fetcher
// (read bursts) and the framebuffer writer (write bursts). Each granted burst
// goes through command hand-off, beat counting and release.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BURST_LEN  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  input  logic [DATA_W-1:0] wr_wdata,
  output logic              wr_wack,
  output logic              sd_cmd_valid,
  input  logic              sd_cmd_ready,
  output logic              sd_cmd_we,
  output logic [ADDR_W-1:0] sd_cmd_addr,
  input  logic              sd_wreq,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic [DATA_W-1:0] sd_rdata,
  input  logic              sd_rvalid
);

  localparam int BEAT_W = beat_cnt_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN);

  arb_state_e        state_reg;
  arb_state_e        state_next;
  logic              owner_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic              cmd_we_reg;
  logic              cmd_valid_reg;
  logic              vid_gnt_reg;
  logic              wr_gnt_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  logic [DATA_W-1:0] vid_rdata_reg;
  logic              vid_rvalid_reg;

  logic              arb_valid;
  logic              arb_owner;
  logic              rd_beat;
  logic              wr_beat;
  logic              wr_xfer;
  logic              burst_done;

  sdram_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .mem_clk   (mem_clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .wr_req    (wr_req),
    .grant_en  (state_reg == IDLE),
    .win_valid (arb_valid),
    .win_owner (arb_owner)
  );

  // State register
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: IDLE -> CMD on a win, CMD -> XFER on handshake, XFER -> IDLE on last beat
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_valid)    state_next = CMD;
      CMD:     if (sd_cmd_ready) state_next = XFER;
      XFER:    if (burst_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: beats only count for the current owner while in XFER
  always_comb begin
    wr_xfer    = (state_reg == XFER) && (owner_reg == OWN_WR);
    rd_beat    = (state_reg == XFER) && (owner_reg == OWN_VID) && sd_rvalid;
    wr_beat    = wr_xfer && sd_wreq;
    burst_done = (rd_beat || wr_beat) && ((beat_cnt_reg + BEAT_W'(1)) == BEAT_LAST);
    wr_wack    = wr_beat;
    sd_wdata   = wr_xfer ? wr_wdata : '0;
  end

  // Command, grant, beat counter and read-data registers
  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= 1'(OWN_VID);
      cmd_addr_reg   <= '0;
      cmd_we_reg     <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      vid_gnt_reg    <= 1'b0;
      wr_gnt_reg     <= 1'b0;
      beat_cnt_reg   <= '0;
      vid_rdata_reg  <= '0;
      vid_rvalid_reg <= 1'b0;
    end else begin
      vid_gnt_reg    <= 1'b0;
      wr_gnt_reg     <= 1'b0;
      vid_rvalid_reg <= rd_beat;
      if (rd_beat) begin
        vid_rdata_reg <= sd_rdata;
      end
      if (state_reg == IDLE && arb_valid) begin
        owner_reg     <= arb_owner;
        cmd_we_reg    <= arb_owner;
        cmd_addr_reg  <= (arb_owner == OWN_WR) ? wr_addr : vid_addr;
        cmd_valid_reg <= 1'b1;
      end
      if (state_reg == CMD && sd_cmd_ready) begin
        cmd_valid_reg <= 1'b0;
        vid_gnt_reg   <= (owner_reg == OWN_VID);
        wr_gnt_reg    <= (owner_reg == OWN_WR);
        beat_cnt_reg  <= '0;
      end
      if (rd_beat || wr_beat) begin
        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
      end
    end
  end

  assign sd_cmd_valid = cmd_valid_reg;
  assign sd_cmd_we    = cmd_we_reg;
  assign sd_cmd_addr  = cmd_addr_reg;
  assign vid_gnt      = vid_gnt_reg;
  assign wr_gnt       = wr_gnt_reg;
  assign vid_rdata    = vid_rdata_reg;
  assign vid_rvalid   = vid_rvalid_reg;

  // Requesters must hold their request until the grant pulse
  vid_req_held: assert property (@(posedge mem_clk) disable iff (reset)
                                 (vid_req && !vid_gnt) |=> vid_req);
  wr_req_held:  assert property (@(posedge mem_clk) disable iff (reset)
                                 (wr_req && !wr_gnt) |=> wr_req);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic              mem_clk = 1'b0;
  logic              reset = 1'b1;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic              wr_gnt;
  logic [DATA_W-1:0] wr_wdata = '0;
  logic              wr_wack;
  logic              sd_cmd_valid;
  logic              sd_cmd_ready = 1'b0;
  logic              sd_cmd_we;
  logic [ADDR_W-1:0] sd_cmd_addr;
  logic              sd_wreq = 1'b0;
  logic [DATA_W-1:0] sd_wdata;
  logic [DATA_W-1:0] sd_rdata = '0;
  logic              sd_rvalid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 mem_clk = ~mem_clk;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(8), .STARVE_MAX(4)
  ) dut (
    .mem_clk(mem_clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
    .wr_wdata(wr_wdata), .wr_wack(wr_wack),
    .sd_cmd_valid(sd_cmd_valid), .sd_cmd_ready(sd_cmd_ready),
    .sd_cmd_we(sd_cmd_we), .sd_cmd_addr(sd_cmd_addr),
    .sd_wreq(sd_wreq), .sd_wdata(sd_wdata),
    .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  // Wait (bounded) for a command to appear on the controller port
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sd_cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Controller accepts the pending command; returns in the grant-pulse cycle
  task automatic handshake();
    sd_cmd_ready = 1'b1;
    tick();
    sd_cmd_ready = 1'b0;
  endtask

  // Controller side of a full burst: consecutive read or write beats
  task automatic serve_beats(input bit we, input logic [DATA_W-1:0] base);
    for (int i = 0; i < 8; i++) begin
      if (we) sd_wreq = 1'b1;
      else begin
        sd_rvalid = 1'b1;
        sd_rdata  = base + DATA_W'(i);
      end
      tick();
    end
    sd_wreq   = 1'b0;
    sd_rvalid = 1'b0;
    sd_rdata  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (sd_cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid: got %b expected 0", sd_cmd_valid); end
    n_cmp++; if (sd_cmd_we !== 1'b0) begin n_err++; $display("FAIL reset_cmd_we: got %b expected 0", sd_cmd_we); end
    n_cmp++; if (sd_cmd_addr !== '0) begin n_err++; $display("FAIL reset_cmd_addr: got %h expected 0", sd_cmd_addr); end
    n_cmp++; if ({vid_gnt, wr_gnt, vid_rvalid, wr_wack} !== 4'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 0000", {vid_gnt, wr_gnt, vid_rvalid, wr_wack}); end
    n_cmp++; if (vid_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", vid_rdata); end
    reset = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_video_only();
    vid_addr = 22'h000100;
    vid_req  = 1'b1;
    tick();
    n_cmp++; if (sd_cmd_valid !== 1'b1) begin n_err++; $display("FAIL vid_cmd_valid: got %b expected 1", sd_cmd_valid); end
    n_cmp++; if (sd_cmd_we !== 1'b0) begin n_err++; $display("FAIL vid_cmd_we: got %b expected 0", sd_cmd_we); end
    n_cmp++; if (sd_cmd_addr !== 22'h000100) begin n_err++; $display("FAIL vid_cmd_addr: got %h expected 000100", sd_cmd_addr); end
    repeat (2) begin
      tick();
      n_cmp++; if (sd_cmd_valid !== 1'b1 || sd_cmd_addr !== 22'h000100) begin n_err++; $display("FAIL vid_cmd_hold: got valid %b addr %h expected 1 000100", sd_cmd_valid, sd_cmd_addr); end
    end
    handshake();
    n_cmp++; if (vid_gnt !== 1'b1) begin n_err++; $display("FAIL vid_gnt_pulse: got %b expected 1", vid_gnt); end
    n_cmp++; if (sd_cmd_valid !== 1'b0) begin n_err++; $display("FAIL vid_cmd_drop: got %b expected 0", sd_cmd_valid); end
    tick();
    n_cmp++; if (vid_gnt !== 1'b0) begin n_err++; $display("FAIL vid_gnt_one_cycle: got %b expected 0", vid_gnt); end
    vid_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = 16'hA000 + 16'(i);
      tick();
      n_cmp++; if (vid_rvalid !== 1'b1 || vid_rdata !== 16'hA000 + 16'(i)) begin n_err++; $display("FAIL vid_beat%0d: got v=%b d=%h expected 1 %h", i, vid_rvalid, vid_rdata, 16'hA000 + 16'(i)); end
      n_cmp++; if (vid_gnt !== 1'b0) begin n_err++; $display("FAIL vid_gnt_extra%0d: got %b expected 0", i, vid_gnt); end
    end
    // Ninth beat arrives after the burst has ended: must be dropped
    sd_rvalid = 1'b1;
    sd_rdata  = 16'hBEEF;
    tick();
    sd_rvalid = 1'b0;
    n_cmp++; if (vid_rvalid !== 1'b0) begin n_err++; $display("FAIL vid_burst_end: got %b expected 0", vid_rvalid); end
    n_cmp++; if (sd_cmd_valid !== 1'b0) begin n_err++; $display("FAIL vid_idle_cmd: got %b expected 0", sd_cmd_valid); end
    $display("video burst addr 000100 done");
  endtask

  task automatic test_writer_only();
    int acks;
    acks     = 0;
    wr_addr  = 22'h3FFFF8;
    wr_req   = 1'b1;
    tick();
    n_cmp++; if (sd_cmd_valid !== 1'b1 || sd_cmd_we !== 1'b1) begin n_err++; $display("FAIL wr_cmd: got valid %b we %b expected 1 1", sd_cmd_valid, sd_cmd_we); end
    n_cmp++; if (sd_cmd_addr !== 22'h3FFFF8) begin n_err++; $display("FAIL wr_cmd_addr: got %h expected 3ffff8", sd_cmd_addr); end
    handshake();
    n_cmp++; if (wr_gnt !== 1'b1 || vid_gnt !== 1'b0) begin n_err++; $display("FAIL wr_gnt_pulse: got wr %b vid %b expected 1 0", wr_gnt, vid_gnt); end
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sd_wreq  = (i % 2 == 1);
      wr_wdata = 16'h5A00 + 16'(i);
      #1;
      n_cmp++; if (wr_wack !== sd_wreq) begin n_err++; $display("FAIL wr_wack_cyc%0d: got %b expected %b", i, wr_wack, sd_wreq); end
      if (sd_wreq) begin
        n_cmp++; if (sd_wdata !== 16'h5A00 + 16'(i)) begin n_err++; $display("FAIL wr_sd_wdata_cyc%0d: got %h expected %h", i, sd_wdata, 16'h5A00 + 16'(i)); end
      end
      if (wr_wack === 1'b1) acks++;
      tick();
    end
    // Extra wreq after the eighth beat: no further acks
    for (int i = 0; i < 2; i++) begin
      sd_wreq = 1'b1;
      #1;
      if (wr_wack === 1'b1) acks++;
      tick();
    end
    sd_wreq = 1'b0;
    n_cmp++; if (acks != 8) begin n_err++; $display("FAIL wr_ack_count: got %0d expected 8", acks); end
    $display("write burst addr 3ffff8 done, %0d acks", acks);
  endtask

  task automatic test_simultaneous();
    bit ok;
    vid_addr = 22'h000200;
    wr_addr  = 22'h001000;
    vid_req  = 1'b1;
    wr_req   = 1'b1;
    tick();
    n_cmp++; if (sd_cmd_valid !== 1'b1 || sd_cmd_we !== 1'b0) begin n_err++; $display("FAIL simul_video_wins: got valid %b we %b expected 1 0", sd_cmd_valid, sd_cmd_we); end
    handshake();
    n_cmp++; if (vid_gnt !== 1'b1 || wr_gnt !== 1'b0) begin n_err++; $display("FAIL simul_gnt: got vid %b wr %b expected 1 0", vid_gnt, wr_gnt); end
    tick();
    vid_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = 16'h1100 + 16'(i);
      tick();
      n_cmp++; if (wr_gnt !== 1'b0) begin n_err++; $display("FAIL simul_wr_gnt_early%0d: got %b expected 0", i, wr_gnt); end
    end
    sd_rvalid = 1'b0;
    wait_cmd(ok);
    n_cmp++; if (!ok || sd_cmd_we !== 1'b1 || sd_cmd_addr !== 22'h001000) begin n_err++; $display("FAIL simul_wr_next: got ok %b we %b addr %h expected 1 1 001000", ok, sd_cmd_we, sd_cmd_addr); end
    handshake();
    n_cmp++; if (wr_gnt !== 1'b1) begin n_err++; $display("FAIL simul_wr_gnt: got %b expected 1", wr_gnt); end
    tick();
    wr_req = 1'b0;
    serve_beats(1'b1, '0);
    $display("simultaneous: video then writer granted");
  endtask

  task automatic test_starvation();
    bit ok;
    bit exp_we;
    vid_addr = 22'h000300;
    wr_addr  = 22'h002000;
    vid_req  = 1'b1;
    wr_req   = 1'b1;
    for (int g = 0; g < 11; g++) begin
      exp_we = (g == 4) || (g == 9);
      wait_cmd(ok);
      n_cmp++; if (!ok || sd_cmd_we !== exp_we) begin n_err++; $display("FAIL starve_order_g%0d: got ok %b we %b expected 1 %b", g, ok, sd_cmd_we, exp_we); end
      if (!ok) break;
      handshake();
      n_cmp++; if (vid_gnt !== !exp_we || wr_gnt !== exp_we) begin n_err++; $display("FAIL starve_gnt_g%0d: got vid %b wr %b expected %b %b", g, vid_gnt, wr_gnt, !exp_we, exp_we); end
      $display("grant %0d to %s", g, exp_we ? "W" : "V");
      tick();
      if (g == 9)  wr_req  = 1'b0;
      if (g == 10) vid_req = 1'b0;
      serve_beats(exp_we, 16'h3300);
    end
    vid_req = 1'b0;
    wr_req  = 1'b0;
    tick();
  endtask

  task automatic test_stray_beats();
    for (int i = 0; i < 3; i++) begin
      sd_rvalid = 1'b1;
      sd_wreq   = 1'b1;
      sd_rdata  = 16'hFFFF;
      #1;
      n_cmp++; if (wr_wack !== 1'b0) begin n_err++; $display("FAIL stray_wack%0d: got %b expected 0", i, wr_wack); end
      tick();
      n_cmp++; if (vid_rvalid !== 1'b0 || sd_cmd_valid !== 1'b0) begin n_err++; $display("FAIL stray_rvalid%0d: got rv %b cv %b expected 0 0", i, vid_rvalid, sd_cmd_valid); end
    end
    sd_rvalid = 1'b0;
    sd_wreq   = 1'b0;
    sd_rdata  = '0;
    vid_addr  = 22'h000400;
    vid_req   = 1'b1;
    tick();
    n_cmp++; if (sd_cmd_valid !== 1'b1 || sd_cmd_addr !== 22'h000400) begin n_err++; $display("FAIL stray_then_grant: got valid %b addr %h expected 1 000400", sd_cmd_valid, sd_cmd_addr); end
    handshake();
    tick();
    vid_req = 1'b0;
    serve_beats(1'b0, 16'h4400);
    tick();
    $display("stray beats ignored");
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int acks;
    acks     = 0;
    vid_addr = 22'h000500;
    vid_req  = 1'b1;
    tick();
    handshake();
    tick();
    vid_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sd_rvalid = 1'b1;
      sd_rdata  = 16'h5500 + 16'(i);
      tick();
    end
    // Beat 3 in flight when reset hits mid-cycle
    sd_rvalid = 1'b1;
    sd_rdata  = 16'h5503;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (vid_rvalid !== 1'b0 || vid_rdata !== '0) begin n_err++; $display("FAIL rst_mid_rdata: got v=%b d=%h expected 0 0", vid_rvalid, vid_rdata); end
    n_cmp++; if ({sd_cmd_valid, sd_cmd_we, vid_gnt, wr_gnt, wr_wack} !== 5'b0 || sd_cmd_addr !== '0) begin n_err++; $display("FAIL rst_mid_outputs: got %b addr %h expected 00000 0", {sd_cmd_valid, sd_cmd_we, vid_gnt, wr_gnt, wr_wack}, sd_cmd_addr); end
    sd_rvalid = 1'b0;
    sd_rdata  = '0;
    tick();
    tick();
    reset = 1'b0;
    wr_addr = 22'h006000;
    wr_req  = 1'b1;
    wait_cmd(ok);
    n_cmp++; if (!ok || sd_cmd_we !== 1'b1 || sd_cmd_addr !== 22'h006000) begin n_err++; $display("FAIL rst_regrant: got ok %b we %b addr %h expected 1 1 006000", ok, sd_cmd_we, sd_cmd_addr); end
    handshake();
    n_cmp++; if (wr_gnt !== 1'b1) begin n_err++; $display("FAIL rst_regrant_gnt: got %b expected 1", wr_gnt); end
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sd_wreq = 1'b1;
      #1;
      if (wr_wack === 1'b1) acks++;
      tick();
    end
    sd_wreq = 1'b0;
    n_cmp++; if (acks != 8) begin n_err++; $display("FAIL rst_beat_restart: got %0d acks expected 8", acks); end
    $display("reset mid-burst recovered, %0d acks", acks);
  endtask

  initial begin
    test_reset();
    test_video_only();
    test_writer_only();
    test_simultaneous();
    test_starvation();
    test_stray_beats();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
